power_ctrl: RTL

POWER_CTRL -- requirements
Module: power_ctrl

---
 rtl/power_ctrl.sv | 111 +++++++++++
 1 files changed

// File: rtl/power_ctrl.sv
// rtl/power_ctrl.sv - iterative unsigned base^power engine (4-bit operands, 8-bit result); optional saturation via POWER_CTRL_SAT_EN
module power_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] base,
    input  logic [3:0] power,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic       ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_n;
    logic        accept;
    logic [3:0]  base_q;
    logic [3:0]  cnt;
    logic [7:0]  acc;
    logic [11:0] product;
    logic        prod_ovf;
    logic [7:0]  acc_next;

    // Full-width product so overflow is visible before truncation
    assign product  = {4'b0000, acc} * {8'h00, base_q};
    assign prod_ovf = |product[11:8];

`ifdef POWER_CTRL_SAT_EN
    // Once the running value has overflowed it stays pinned at all-ones
    assign acc_next = (prod_ovf || ovf) ? 8'hFF : product[7:0];
`else
    // Plain modulo-256 arithmetic: keep the low byte of every product
    assign acc_next = product[7:0];
`endif

    // Status outputs decode directly from the state register
    assign busy = (state == MULT);
    assign done = (state == DONE);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic; a new request is only taken when not multiplying
    always_comb begin
        state_n = state;
        accept  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_n = MULT;
                end
            end
            MULT: begin
                if (cnt == 4'd0) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_n = MULT;
                end else begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Operand latch, iteration datapath, result and sticky overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q <= 4'd0;
            cnt    <= 4'd0;
            acc    <= 8'd1;
            result <= 8'h00;
            ovf    <= 1'b0;
        end else if (accept) begin
            base_q <= base;
            cnt    <= power;
            acc    <= 8'd1;
            ovf    <= 1'b0;
        end else if (state == MULT) begin
            if (cnt != 4'd0) begin
                acc <= acc_next;
                cnt <= cnt - 4'd1;
                if (prod_ovf) begin
                    ovf <= 1'b1;
                end
            end else begin
                result <= acc;
            end
        end
    end

endmodule
